// File: rtl/multiplier_core_if.sv
// Handshake and result bus between the multiplier core and its user.
interface multiplier_core_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_start;
  logic             op_clear;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [1:0]       state;
  logic [WIDTH-1:0] U;
  logic [WIDTH-1:0] V;
  logic             op_done;

  // Requester side: issues operands and commands, observes the result.
  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  state, U, V, op_done
  );

  // Core side.
  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output state, U, V, op_done
  );
endinterface

// File: rtl/multiplier_core.sv
// Sequential unsigned shift-add multiplier: one add/shift step per clock,
// {U,V} carries the running partial product and ends as the full product.
module multiplier_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  multiplier_core_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [5:0]       count_q, count_d;
  logic [WIDTH:0]   sum;

  // Register all state; reset abandons any operation immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      x_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      x_q     <= x_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath: clear wins over everything, then the state action.
  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    x_d     = x_q;
    count_d = count_q;
    // Carry kept as the top bit; it becomes the MSB of U after the shift.
    sum     = {1'b0, u_q} + (v_q[0] ? {1'b0, x_q} : '0);

    if (bus.op_clear) begin
      state_d = IDLE;
      u_d     = '0;
      v_d     = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          u_d = '0;
          v_d = '0;
          if (bus.op_start) begin
            x_d     = bus.multiplicand;
            v_d     = bus.multiplier;
            count_d = '0;
            state_d = EXEC;
          end
        end
        EXEC: begin
          // {c, sum, V} shifted right by one; the consumed multiplier bit drops off.
          u_d     = sum[WIDTH:1];
          v_d     = {sum[0], v_q[WIDTH-1:1]};
          count_d = count_q + 6'd1;
          if (count_q == LAST_STEP) state_d = DONE;
        end
        DONE: begin
          // Product held until cleared.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.state   = state_q;
  assign bus.U       = u_q;
  assign bus.V       = v_q;
  assign bus.op_done = (state_q == DONE);

endmodule

// File: tb/tb_multiplier_core.sv
// Randomised self-checking bench for multiplier_core against an arithmetic model.
module tb_multiplier_core;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  multiplier_core_if #(.WIDTH(32)) bus ();

  multiplier_core #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {U,V} after n steps: product of X with the low n bits of Y,
  // aligned to the top, with the unconsumed Y bits in the low part.
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input int n);
    logic [63:0] ylow;
    if (n >= 32) return 64'(x) * 64'(y);
    ylow = 64'(y) & ((64'd1 << n) - 64'd1);
    return ((64'(x) * ylow) << (32 - n)) | (64'(y) >> n);
  endfunction

  // Start an operation, walk all 32 steps checking every cycle; optionally
  // pulse a (to-be-ignored) start with fresh operands before step inject_at.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int inject_at, input string label);
    logic [63:0] exp;
    @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = x;
    bus.multiplier   = y;
    @(posedge clk); #1;
    bus.op_start     = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    for (int n = 0; n <= 32; n++) begin
      if (n > 0) begin
        @(negedge clk);
        bus.op_start = (n == inject_at);
        if (n == inject_at) begin
          bus.multiplicand = $urandom;
          bus.multiplier   = $urandom;
        end
        @(posedge clk); #1;
        bus.op_start = 1'b0;
      end
      exp = model(x, y, n);
      total++;
      if (bus.state !== ((n < 32) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL %s state step=%0d got=%b exp=%b", label, n, bus.state, (n < 32) ? 2'b01 : 2'b10);
      end
      total++;
      if (bus.op_done !== (n == 32)) begin
        bad++;
        $display("FAIL %s op_done step=%0d got=%b exp=%b", label, n, bus.op_done, (n == 32));
      end
      total++;
      if ({bus.U, bus.V} !== exp) begin
        bad++;
        $display("FAIL %s uv step=%0d got=%h exp=%h", label, n, {bus.U, bus.V}, exp);
      end
    end
  endtask

  // Pulse op_clear and confirm the core is back in IDLE with zeroed U/V.
  task automatic clear_op(input string label);
    @(negedge clk);
    bus.op_clear = 1'b1;
    @(posedge clk); #1;
    bus.op_clear = 1'b0;
    total++;
    if (bus.state !== 2'b00 || bus.U !== 32'h0 || bus.V !== 32'h0 || bus.op_done !== 1'b0) begin
      bad++;
      $display("FAIL %s clear got state=%b U=%h V=%h done=%b exp state=00 U=0 V=0 done=0",
               label, bus.state, bus.U, bus.V, bus.op_done);
    end
  endtask

  task automatic test_reset();
    reset_n          = 1'b0;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #2;
    total++;
    if (bus.state !== 2'b00 || bus.U !== 32'h0 || bus.V !== 32'h0 || bus.op_done !== 1'b0) begin
      bad++;
      $display("FAIL reset got state=%b U=%h V=%h done=%b exp 00/0/0/0", bus.state, bus.U, bus.V, bus.op_done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (bus.state !== 2'b00 || {bus.U, bus.V} !== 64'h0) begin
        bad++;
        $display("FAIL idle_hold got state=%b uv=%h exp 00/0", bus.state, {bus.U, bus.V});
      end
    end
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, -1, "basic");
    repeat (4) begin
      @(posedge clk); #1;
      total++;
      if (bus.state !== 2'b10 || bus.op_done !== 1'b1 || {bus.U, bus.V} !== 64'h0000_0000_0000_000F) begin
        bad++;
        $display("FAIL basic_hold got state=%b done=%b uv=%h exp 10/1/000000000000000f",
                 bus.state, bus.op_done, {bus.U, bus.V});
      end
    end
    clear_op("basic");
  endtask

  task automatic test_corners();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "all_ones");
    total++;
    if ({bus.U, bus.V} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL all_ones_const got=%h exp=fffffffe00000001", {bus.U, bus.V});
    end
    clear_op("all_ones");
    run_op(32'h0, 32'hDEAD_BEEF, -1, "zero");
    total++;
    if ({bus.U, bus.V} !== 64'h0) begin
      bad++;
      $display("FAIL zero_const got=%h exp=0", {bus.U, bus.V});
    end
    clear_op("zero");
    run_op(32'h8000_0000, 32'd2, -1, "shift");
    total++;
    if ({bus.U, bus.V} !== 64'h0000_0001_0000_0000) begin
      bad++;
      $display("FAIL shift_const got=%h exp=0000000100000000", {bus.U, bus.V});
    end
    clear_op("shift");
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom;
      if (i == 0) y = 32'h8000_0001;
      run_op(x, y, (i == 3) ? 17 : -1, $sformatf("rand%0d", i));
      clear_op($sformatf("rand%0d", i));
    end
  endtask

  task automatic test_ignored();
    run_op(32'd7, 32'd6, 10, "ignored");
    @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = 32'd100;
    bus.multiplier   = 32'd100;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    repeat (2) begin
      total++;
      if (bus.state !== 2'b10 || {bus.U, bus.V} !== 64'd42) begin
        bad++;
        $display("FAIL ignored_done got state=%b uv=%h exp 10/2a", bus.state, {bus.U, bus.V});
      end
      @(posedge clk); #1;
    end
    clear_op("ignored");
  endtask

  task automatic test_clear_priority();
    @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = 32'd123;
    bus.multiplier   = 32'd456;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (bus.state !== 2'b01) begin
      bad++;
      $display("FAIL clrprio_pre got state=%b exp=01", bus.state);
    end
    @(negedge clk);
    bus.op_clear = 1'b1;
    bus.op_start = 1'b1;
    @(posedge clk); #1;
    bus.op_clear = 1'b0;
    bus.op_start = 1'b0;
    total++;
    if (bus.state !== 2'b00 || bus.U !== 32'h0 || bus.V !== 32'h0) begin
      bad++;
      $display("FAIL clrprio got state=%b U=%h V=%h exp 00/0/0", bus.state, bus.U, bus.V);
    end
    @(posedge clk); #1;
    total++;
    if (bus.state !== 2'b00) begin
      bad++;
      $display("FAIL clrprio_stay got state=%b exp=00", bus.state);
    end
    run_op(32'd10, 32'd10, -1, "after_clear");
    total++;
    if ({bus.U, bus.V} !== 64'd100) begin
      bad++;
      $display("FAIL after_clear_const got=%h exp=64", {bus.U, bus.V});
    end
    clear_op("after_clear");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.op_start     = 1'b1;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom | 32'h1;
    @(posedge clk); #1;
    bus.op_start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.state !== 2'b00 || bus.U !== 32'h0 || bus.V !== 32'h0 || bus.op_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got state=%b U=%h V=%h done=%b exp 00/0/0/0",
               bus.state, bus.U, bus.V, bus.op_done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.state !== 2'b00 || {bus.U, bus.V} !== 64'h0) begin
      bad++;
      $display("FAIL post_reset_idle got state=%b uv=%h exp 00/0", bus.state, {bus.U, bus.V});
    end
    run_op(32'd9, 32'd9, -1, "post_reset");
    total++;
    if ({bus.U, bus.V} !== 64'd81) begin
      bad++;
      $display("FAIL post_reset_const got=%h exp=51", {bus.U, bus.V});
    end
    clear_op("post_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_ignored();
    test_clear_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiplier_core.md
# multiplier_core

Sequential 32×32 unsigned shift-add multiplier: the controller and datapath that produce the `state`, `U` and `V` buses consumed by the multiplier output stage. On `op_start` it latches its operands and runs 32 add/shift steps, one per clock. `{U,V}` carries the running partial product during EXEC and the final 64-bit product in DONE. It holds DONE until cleared.

## Interface
- `WIDTH`, 32: operand width; `U` and `V` are each `WIDTH` bits. Only 32 is required to be verified.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `op_start` input 1: start request; sampled only in IDLE.
- `op_clear` input 1: return to IDLE from any state.
- `multiplicand` input 32: operand X; sampled on the accepted `op_start` edge.
- `multiplier` input 32: operand Y; sampled on the accepted `op_start` edge.
- `state` output 2: IDLE=2'b00, EXEC=2'b01, DONE=2'b10 (binary encoding). 2'b11 is never produced.
- `U` output 32: upper half of the partial or final product.
- `V` output 32: lower half of the partial or final product, and the remaining multiplier bits during EXEC.
- `op_done` output 1: high exactly while `state`==DONE.

## Operation
- Internal registers:
  - `X` (32 bits): latched multiplicand.
  - `count` (6 bits).
  - `U`, `V`, `state`.
- Reset (`reset_n`=0, asynchronous): `state`=IDLE, `U`=0, `V`=0, `X`=0, `count`=0, `op_done`=0. Any operation in progress is abandoned.
- Priority on each edge: `op_clear` first, then the state action.
- `op_clear`=1 in any state: next `state`=IDLE, `U`=0, `V`=0, `count`=0. A simultaneous `op_start` is ignored.
- IDLE:
  - `U` and `V` hold 0.
  - On `op_start`=1: `X`<=`multiplicand`, `U`<=0, `V`<=`multiplier`, `count`<=0, `state`<=EXEC.
- EXEC, one step per cycle:
  - `sum` = `V[0]` ? (`U`+`X`) : `U`, computed 33 bits wide with carry `c`.
  - Update `{U,V}` <= `{c, sum[31:0], V[31:1]}`, i.e. the 65-bit value `{c,sum,V}` shifted right by 1.
  - `count`<=`count`+1.
  - When the step with `count`==31 completes, `state`<=DONE. Exactly 32 steps are performed.
  - `op_start` during EXEC is ignored. Operands changing during EXEC have no effect.
- DONE:
  - `{U,V}` = `X`×`Y` (64-bit, no truncation); `U`/`V` hold.
  - `op_done`=1.
  - `op_start` is ignored; only `op_clear` (or reset) leaves DONE.
- Arithmetic width rule: the carry `c` must be kept. Dropping it fails the all-ones case.

## Timing
- Accepted `op_start` at edge k:
  - After edge k: `state`=EXEC, `U`=0, `V`=Y.
  - After edge k+n (1≤n≤31): `state`=EXEC, `{U,V}` holds partial step n.
  - After edge k+32: `state`=DONE, `op_done`=1, product valid.
- Latency: 32 cycles from the start edge to DONE.
- Throughput: one product per 34 cycles minimum (start, 32 steps, clear).
- All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- `op_clear` at any edge: IDLE with zeroed `U`/`V` after that edge. A new `op_start` is accepted from the following edge.
- Reset asserted mid-EXEC: outputs go to 0/IDLE immediately, without waiting for a clock. After `reset_n` deasserts, the block waits in IDLE for `op_start`.

## Test plan
- Basic product: X=3, Y=5, `op_start` one cycle → `state`=01 for 32 cycles, then `state`=10, `op_done`=1, `{U,V}`=64'h0000_0000_0000_000F held until `op_clear`.
- Carry path: X=Y=32'hFFFF_FFFF → after 32 cycles `{U,V}`=64'hFFFF_FFFE_0000_0001.
- Zero and shift: X=0, Y=32'hDEAD_BEEF → DONE with `{U,V}`=0. X=32'h8000_0000, Y=2 → `{U,V}`=64'h0000_0001_0000_0000.
- Ignored requests: pulse `op_start` with new operands at EXEC cycle 10 and again in DONE → result unchanged (X=7, Y=6 gives 42), and `state` stays DONE.
- Clear priority: assert `op_clear` at EXEC cycle 5 together with `op_start` → `state`=00, `U`=`V`=0. The next `op_start` (X=10, Y=10) gives 100 after 32 cycles.
- Async reset: drop `reset_n` mid-EXEC between clock edges → `state`=00, `U`=`V`=0, `op_done`=0 before the next edge. After release, a normal operation (X=9, Y=9) gives 81.
